// File: rtl/spi_display_master_pkg.sv
// Shared definitions for the SPI display master: FSM encodings, idle line levels
// and small constant helpers for counter sizing.
package spi_display_master_pkg;

    localparam int unsigned DataWidthDefault = 16;

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StSetup = 3'd1;
    localparam logic [2:0] StLow   = 3'd2;
    localparam logic [2:0] StHigh  = 3'd3;
    localparam logic [2:0] StHold  = 3'd4;
    localparam logic [2:0] StGap   = 3'd5;

    localparam logic SclkIdle = 1'b1;
    localparam logic SsIdle   = 1'b1;
    localparam logic MosiIdle = 1'b1;

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // Bits needed to hold 0..max_count-1, never less than one.
    function automatic int unsigned cnt_width(input int unsigned max_count);
        return (max_count <= 2) ? 1 : $clog2(max_count);
    endfunction

endpackage

// File: rtl/spi_phase_timer.sv
// Loadable down-counter; done_o is high once the count has run out, so a phase
// loaded with N-1 lasts exactly N cycles.
module spi_phase_timer #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clock_i,
    input  logic             rst_low_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic             done_o
);

    logic [WIDTH-1:0] count_q;

    assign done_o = (count_q == '0);

    always_ff @(posedge clock_i or negedge rst_low_i) begin
        if (!rst_low_i) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (!done_o) begin
            count_q <= count_q - WIDTH'(1);
        end
    end

endmodule

// File: rtl/spi_display_master.sv
// SPI master for the Nexys4Display slave: sclk idles high, MSB first, ss active low.
// Line outputs are registered from the next state so they change with the FSM.
module spi_display_master
    import spi_display_master_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DataWidthDefault,
    parameter int unsigned CLK_DIV    = 4,
    parameter int unsigned SS_SETUP   = 2,
    parameter int unsigned SS_HOLD    = 2,
    parameter int unsigned SS_GAP     = 4
) (
    input  logic                  clock_i,
    input  logic                  rst_low_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    output logic                  spi_sclk_o,
    output logic                  spi_ss_o,
    output logic                  spi_mosi_o,
    input  logic                  spi_miso_i,
    output logic [DATA_WIDTH-1:0] rx_data_o,
    output logic                  rx_valid_o
);

    localparam int unsigned GapCycles = max2(SS_GAP, 1);
    localparam int unsigned CntMax    = max2(max2(max2(CLK_DIV, SS_SETUP),
                                                  max2(SS_HOLD, GapCycles)), DATA_WIDTH);
    localparam int unsigned CntW      = cnt_width(CntMax);
    localparam int unsigned BitW      = cnt_width(DATA_WIDTH);

    logic [2:0]            state_q, state_d;
    logic [DATA_WIDTH-1:0] tx_q, tx_d;
    logic [DATA_WIDTH-1:0] rx_sh_q, rx_sh_d;
    logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
    logic [BitW-1:0]       bit_q, bit_d;
    logic                  sclk_q, sclk_d;
    logic                  ss_q, ss_d;
    logic                  mosi_q, mosi_d;
    logic                  rx_valid_q, rx_valid_d;
    logic                  tmr_load;
    logic [CntW-1:0]       tmr_val;
    logic                  tmr_done;

    spi_phase_timer #(
        .WIDTH(CntW)
    ) u_phase_timer (
        .clock_i    (clock_i),
        .rst_low_i  (rst_low_i),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .done_o     (tmr_done)
    );

    always_comb begin
        state_d    = state_q;
        tx_d       = tx_q;
        rx_sh_d    = rx_sh_q;
        rx_data_d  = rx_data_q;
        bit_d      = bit_q;
        mosi_d     = mosi_q;
        rx_valid_d = 1'b0;
        tmr_load   = 1'b0;
        tmr_val    = '0;
        case (state_q)
            StIdle: begin
                if (valid_i) begin
                    state_d  = StSetup;
                    tx_d     = data_i;
                    bit_d    = '0;
                    mosi_d   = data_i[DATA_WIDTH-1];
                    tmr_load = 1'b1;
                    tmr_val  = CntW'(SS_SETUP - 1);
                end
            end
            StSetup: begin
                if (tmr_done) begin
                    state_d  = StLow;
                    tmr_load = 1'b1;
                    tmr_val  = CntW'(CLK_DIV - 1);
                end
            end
            StLow: begin
                if (tmr_done) begin
                    // Capture lines up with the rising sclk the slave samples on.
                    state_d  = StHigh;
                    rx_sh_d  = {rx_sh_q[DATA_WIDTH-2:0], spi_miso_i};
                    tmr_load = 1'b1;
                    tmr_val  = CntW'(CLK_DIV - 1);
                end
            end
            StHigh: begin
                if (tmr_done) begin
                    tmr_load = 1'b1;
                    if (bit_q == BitW'(DATA_WIDTH - 1)) begin
                        state_d = StHold;
                        tmr_val = CntW'(SS_HOLD - 1);
                    end else begin
                        state_d = StLow;
                        tmr_val = CntW'(CLK_DIV - 1);
                        bit_d   = bit_q + BitW'(1);
                        tx_d    = tx_q << 1;
                        mosi_d  = tx_q[DATA_WIDTH-2];
                    end
                end
            end
            StHold: begin
                if (tmr_done) begin
                    state_d    = StGap;
                    mosi_d     = MosiIdle;
                    rx_data_d  = rx_sh_q;
                    rx_valid_d = 1'b1;
                    tmr_load   = 1'b1;
                    tmr_val    = CntW'(GapCycles - 1);
                end
            end
            StGap: begin
                if (tmr_done) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        sclk_d = (state_d != StLow);
        ss_d   = (state_d == StIdle) || (state_d == StGap);
    end

    always_ff @(posedge clock_i or negedge rst_low_i) begin
        if (!rst_low_i) begin
            state_q    <= StIdle;
            tx_q       <= '0;
            rx_sh_q    <= '0;
            rx_data_q  <= '0;
            bit_q      <= '0;
            sclk_q     <= SclkIdle;
            ss_q       <= SsIdle;
            mosi_q     <= MosiIdle;
            rx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_q       <= tx_d;
            rx_sh_q    <= rx_sh_d;
            rx_data_q  <= rx_data_d;
            bit_q      <= bit_d;
            sclk_q     <= sclk_d;
            ss_q       <= ss_d;
            mosi_q     <= mosi_d;
            rx_valid_q <= rx_valid_d;
        end
    end

    assign ready_o    = (state_q == StIdle);
    assign spi_sclk_o = sclk_q;
    assign spi_ss_o   = ss_q;
    assign spi_mosi_o = mosi_q;
    assign rx_data_o  = rx_data_q;
    assign rx_valid_o = rx_valid_q;

endmodule
